// File: rtl/pattern_tx.sv
// pattern_tx: serial frame transmitter.
// Each accepted word goes out as a frame: the 4-bit SYNC pattern (MSB first),
// then DATA_W payload bits (MSB first). With STUFF_EN set, a '1' is inserted
// whenever the last three frame bits since the payload started are 1,0,1, so
// the sync pattern 1010 cannot be mimicked inside the payload or at the tail.
// A one-deep holding buffer lets the next word queue up so frames can run
// back to back.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   din         payload word, sampled on handshake
//   din_valid   payload word offered
//   din_ready   holding buffer empty (handshake on din_valid && din_ready)
//   tx_out      serial line, one bit per clk, registered
//   tx_en       high while tx_out carries a frame bit
//   sync_flag   high while tx_out carries a sync bit
//   stuff_flag  high while tx_out carries a stuffed bit
module pattern_tx #(
   parameter int unsigned DATA_W   = 8,
   parameter logic [3:0]  SYNC     = 4'b1010,
   parameter bit          STUFF_EN = 1'b1,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              tx_out,
   output logic              tx_en,
   output logic              sync_flag,
   output logic              stuff_flag
);

   localparam int CW = $clog2(DATA_W + 1);

   // The state register names what is on the line during the current cycle.
   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_STUFF} state_t;

   state_t            state, state_nx;
   logic              buf_full, buf_full_nx;
   logic [DATA_W-1:0] buf_data;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic [CW-1:0]     rem, rem_nx;        // payload bits not yet on the line
   logic [1:0]        sync_cnt, sync_cnt_nx;
   logic [1:0]        sync_idx;
   logic [2:0]        hist, hist_nx;      // last frame bits since payload start, incl. current
   logic              tx_nx;
   logic              start;              // launch a frame from the buffer on this edge
   logic              hs;

   assign din_ready = !buf_full;
   assign hs        = din_valid && !buf_full;
   assign sync_idx  = 2'd2 - sync_cnt;

   always_comb begin
      state_nx    = state;
      shreg_nx    = shreg;
      rem_nx      = rem;
      sync_cnt_nx = sync_cnt;
      hist_nx     = hist;
      tx_nx       = IDLE_BIT;
      start       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (buf_full) start = 1'b1;
         end
         ST_SYNC: begin
            if (sync_cnt == 2'd3) begin
               state_nx = ST_DATA;
               tx_nx    = shreg[DATA_W-1];
               shreg_nx = shreg << 1;
               rem_nx   = CW'(DATA_W - 1);
               hist_nx  = {2'b00, shreg[DATA_W-1]};
            end else begin
               sync_cnt_nx = sync_cnt + 2'd1;
               tx_nx       = SYNC[sync_idx];
            end
         end
         ST_DATA, ST_STUFF: begin
            // Stuff check comes first so a trailing 1,0,1 still gets its stuff bit.
            if (STUFF_EN && hist == 3'b101) begin
               state_nx = ST_STUFF;
               tx_nx    = 1'b1;
               hist_nx  = {hist[1:0], 1'b1};
            end else if (rem != '0) begin
               state_nx = ST_DATA;
               tx_nx    = shreg[DATA_W-1];
               shreg_nx = shreg << 1;
               rem_nx   = rem - CW'(1);
               hist_nx  = {hist[1:0], shreg[DATA_W-1]};
            end else if (buf_full) begin
               start = 1'b1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      // Only a word already in the buffer before this edge can start a frame;
      // one arriving on the same edge waits in the buffer.
      if (start) begin
         state_nx    = ST_SYNC;
         sync_cnt_nx = 2'd0;
         tx_nx       = SYNC[3];
         shreg_nx    = buf_data;
      end
      // start and hs are exclusive: start needs a full buffer, hs an empty one.
      buf_full_nx = start ? 1'b0 : (hs ? 1'b1 : buf_full);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         buf_full   <= 1'b0;
         buf_data   <= '0;
         shreg      <= '0;
         rem        <= '0;
         sync_cnt   <= 2'd0;
         hist       <= 3'b000;
         tx_out     <= IDLE_BIT;
         tx_en      <= 1'b0;
         sync_flag  <= 1'b0;
         stuff_flag <= 1'b0;
      end else begin
         state      <= state_nx;
         buf_full   <= buf_full_nx;
         if (hs) buf_data <= din;
         shreg      <= shreg_nx;
         rem        <= rem_nx;
         sync_cnt   <= sync_cnt_nx;
         hist       <= hist_nx;
         tx_out     <= tx_nx;
         tx_en      <= (state_nx != ST_IDLE);
         sync_flag  <= (state_nx == ST_SYNC);
         stuff_flag <= (state_nx == ST_STUFF);
      end
   end

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx. Two instances share clock and reset: u_dut with
// stuffing enabled (channel 0) and u_dut_ns with stuffing disabled
// (channel 1). Expected frames are hand-written symbol strings:
//   H/L = sync bit 1/0, 1/0 = payload bit, s = stuffed 1.
module tb_pattern_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn;
   logic [7:0] din0, din1;
   logic       dv0, dv1;
   logic       rdy0, rdy1, txo0, txo1, ten0, ten1, syf0, syf1, stf0, stf1;

   pattern_tx #(.DATA_W(8), .SYNC(4'b1010), .STUFF_EN(1'b1), .IDLE_BIT(1'b0)) u_dut (
      .clk(clk), .rstn(rstn), .din(din0), .din_valid(dv0), .din_ready(rdy0),
      .tx_out(txo0), .tx_en(ten0), .sync_flag(syf0), .stuff_flag(stf0));

   pattern_tx #(.DATA_W(8), .SYNC(4'b1010), .STUFF_EN(1'b0), .IDLE_BIT(1'b0)) u_dut_ns (
      .clk(clk), .rstn(rstn), .din(din1), .din_valid(dv1), .din_ready(rdy1),
      .tx_out(txo1), .tx_en(ten1), .sync_flag(syf1), .stuff_flag(stf1));

   int  n_tests = 0;
   int  n_fail  = 0;
   byte q0[$];
   byte q1[$];
   bit  mon_en     = 1'b0;
   bit  chk_contig = 1'b0;
   bit  prev_en    = 1'b0;

   function automatic logic [2:0] decode(byte c);
      case (c)
         "H":     return 3'b110;
         "L":     return 3'b010;
         "1":     return 3'b100;
         "0":     return 3'b000;
         "s":     return 3'b101;
         default: return 3'b111;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every frame bit pops one expected symbol {tx_out,sync,stuff}.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int ch = 0; ch < 2; ch++) begin
            logic       en;
            logic [2:0] act;
            logic [2:0] exp;
            int         sz;
            byte        c;
            en  = (ch == 0) ? ten0 : ten1;
            act = (ch == 0) ? {txo0, syf0, stf0} : {txo1, syf1, stf1};
            sz  = (ch == 0) ? q0.size() : q1.size();
            n_tests++;
            if (en) begin
               if (sz == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_bit ch%0d: got out/sync/stuff=%b want no frame", ch, act);
               end else begin
                  if (ch == 0) c = q0.pop_front(); else c = q1.pop_front();
                  exp = decode(c);
                  if (act !== exp) begin
                     n_fail++;
                     $display("FAIL frame_bit ch%0d sym %s: got out/sync/stuff=%b want %b", ch, c, act, exp);
                  end
               end
            end else if (act !== 3'b000) begin
               n_fail++;
               $display("FAIL idle_line ch%0d: got out/sync/stuff=%b want 000", ch, act);
            end
         end
         if (chk_contig && prev_en) begin
            n_tests++;
            if (!ten0 && q0.size() > 0) begin
               n_fail++;
               $display("FAIL contiguous: got tx_en=0 with %0d bits pending want tx_en=1", q0.size());
            end
         end
         prev_en = ten0;
      end
   end

   // Called at a negedge; returns at the negedge after the handshake edge
   // with din_valid still high.
   task automatic send(input int ch, input logic [7:0] w, input string exp);
      int n;
      n = 0;
      if (ch == 0) begin din0 = w; dv0 = 1'b1; end
      else         begin din1 = w; dv1 = 1'b1; end
      while (((ch == 0) ? rdy0 : rdy1) !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout ch%0d: got din_ready=0 for 200 cycles want 1 (word %h)", ch, w);
         if (ch == 0) dv0 = 1'b0; else dv1 = 1'b0;
         return;
      end
      for (int i = 0; i < exp.len(); i++) begin
         if (ch == 0) q0.push_back(exp[i]); else q1.push_back(exp[i]);
      end
      @(negedge clk);
      chk($sformatf("ready_low_after_hs ch%0d", ch), {31'd0, (ch == 0) ? rdy0 : rdy1}, 32'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && !ten0 && !ten1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (n >= 500) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d bits pending want 0", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rstn = 1'b0; din0 = 8'h00; din1 = 8'h00; dv0 = 1'b0; dv1 = 1'b0;
      #3;
      chk("reset ch0 out/en/sync/stuff/ready", {27'd0, txo0, ten0, syf0, stf0, rdy0}, 32'h1);
      chk("reset ch1 out/en/sync/stuff/ready", {27'd0, txo1, ten1, syf1, stf1, rdy1}, 32'h1);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Single 00: 12 frame bits, first sync one cycle after the handshake edge.
      send(0, 8'h00, "HLHL00000000");
      dv0 = 1'b0;
      chk("latency idle after hs", {31'd0, ten0}, 32'd0);
      @(negedge clk);
      chk("latency sync next cycle", {30'd0, ten0, syf0}, 32'h3);
      drain();

      // A5 with stuffing: two stuff bits, including one at the frame tail.
      send(0, 8'hA5, "HLHL101s00101s");
      dv0 = 1'b0;
      drain();

      // A5 without stuffing.
      send(1, 8'hA5, "HLHL10100101");
      dv1 = 1'b0;
      drain();

      // Three words with din_valid held: contiguous frames, order preserved.
      chk_contig = 1'b1;
      send(0, 8'hFF, "HLHL11111111");
      send(0, 8'h00, "HLHL00000000");
      send(0, 8'h3C, "HLHL00111100");
      dv0 = 1'b0;
      drain();
      chk_contig = 1'b0;

      // Reset during payload bit 3 of FF with 00 buffered: both discarded.
      send(0, 8'hFF, "HLHL11111111");
      send(0, 8'h00, "HLHL00000000");
      dv0 = 1'b0;
      n = 0;
      while (!(ten0 && !syf0) && n < 100) begin @(negedge clk); n++; end
      chk("reach payload", {31'd0, ten0 && !syf0}, 32'd1);
      repeat (3) @(negedge clk);
      #1 rstn = 1'b0;
      q0.delete();
      q1.delete();
      #1;
      chk("async abort out/en/sync/stuff", {28'd0, txo0, ten0, syf0, stf0}, 32'd0);
      @(negedge clk);
      #1 rstn = 1'b1;
      #1 chk("ready after release", {31'd0, rdy0}, 32'd1);
      repeat (40) @(negedge clk);

      // 05 ends 1,0,1,s; next word handshaked on the edge ending the stuff bit.
      send(0, 8'h05, "HLHL00000101s");
      dv0 = 1'b0;
      n = 0;
      while (stf0 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("reach tail stuff", {31'd0, stf0}, 32'd1);
      send(0, 8'h3C, "HLHL00111100");
      dv0 = 1'b0;
      chk("tail gap idle", {31'd0, ten0}, 32'd0);
      @(negedge clk);
      chk("sync after gap", {30'd0, ten0, syf0}, 32'h3);
      drain();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The module SHALL use reset rstn, asynchronous, active-low, and clock clk.
REQ-002 Parameter DATA_W, default 8, SHALL set the payload width in bits (legal range 1..32).
REQ-003 Parameter SYNC, default 4'b1010, SHALL be the 4-bit sync pattern, sent MSB first.
REQ-004 Parameter STUFF_EN, default 1, SHALL enable (1) or disable (0) payload bit stuffing.
REQ-005 Parameter IDLE_BIT, default 1'b0, SHALL set the line level when no frame is in progress.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 din  input  DATA_W  payload word, sampled at handshake.
REQ-009 din_valid  input  1  payload word offered.
REQ-010 din_ready  output  1  one-deep holding buffer empty; word accepted on any edge where din_valid && din_ready.
REQ-011 tx_out  output  1  serial line, one bit per clk, registered.
REQ-012 tx_en  output  1  high for every cycle tx_out carries a frame bit (sync, payload or stuff).
REQ-013 sync_flag  output  1  high while tx_out carries a sync bit.
REQ-014 stuff_flag  output  1  high while tx_out carries a stuffed bit.

Function
REQ-015 Frame format SHALL be: the 4 SYNC bits, then the DATA_W payload bits MSB first, with stuffed bits inserted per REQ-020.
REQ-016 The FSM SHALL have exactly the states IDLE, SYNC, DATA and STUFF; all outputs SHALL be registered from the FSM.
REQ-017 Holding buffer: a handshake SHALL set it full on that edge; din_ready SHALL equal !buffer_full.
REQ-018 IDLE -> SYNC on the first edge on which the buffer is full; on that same edge the buffer word SHALL move to the shift register and the buffer SHALL clear. The first sync bit therefore appears one cycle after the handshake cycle.
REQ-019 SYNC SHALL last exactly 4 cycles; a 2-bit counter selects SYNC[3]..SYNC[0]; SYNC -> DATA after SYNC[0].
REQ-020 Stuffing (STUFF_EN=1): a 3-bit history of frame bits sent since DATA entry SHALL be kept, cleared on DATA entry. Stuffed bits enter the history. The FSM SHALL go to STUFF for one cycle, driving tx_out=1, whenever the history equals 3'b101. This includes after the last payload bit, so "1010" can never appear in payload or across a frame tail into the idle level.
REQ-021 STUFF -> DATA if payload bits remain; otherwise apply the end-of-frame rule (REQ-022).
REQ-022 End of frame: after the last payload bit, or its trailing stuff bit, the FSM SHALL go directly to SYNC with no gap if the buffer is full (loading it as in REQ-018), else to IDLE.
REQ-023 A new word SHALL be accepted during any state while the buffer is empty; the in-flight frame SHALL never be modified.
REQ-024 STUFF_EN=0: the STUFF state SHALL be unreachable; frames are exactly 4+DATA_W bits.
REQ-025 In IDLE: tx_out=IDLE_BIT and tx_en=sync_flag=stuff_flag=0.
REQ-026 Handshake and end-of-frame on the same edge: the word SHALL be captured into the buffer, and the FSM SHALL go to IDLE. The next frame then starts one cycle later per REQ-018.

Reset
REQ-027 When rstn is asserted, the FSM SHALL go to IDLE and the buffer, shift register, counters and history SHALL clear.
REQ-028 Reset values SHALL be: tx_out=IDLE_BIT, tx_en=0, sync_flag=0, stuff_flag=0, din_ready=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously. The aborted word and any buffered word SHALL be discarded, never resent.

Verification
REQ-030 din=8'h00, single word -> tx_out 1,0,1,0 then eight 0s; tx_en high 12 cycles; sync_flag high first 4; stuff_flag never high.
REQ-031 din=8'hA5 -> payload phase 1,0,1,S1,0,0,1,0,1,S1 (S=stuff, stuff_flag high); tx_en high 14 cycles.
REQ-032 din=8'hA5 with STUFF_EN=0 -> 1,0,1,0,1,0,1,0,0,1,0,1; tx_en high 12 cycles; stuff_flag stays 0.
REQ-033 Three words 8'hFF, 8'h00, 8'h3C with din_valid held high -> frames contiguous, tx_en never drops between them; din_ready low while buffer full; word order preserved.
REQ-034 rstn pulsed low during payload bit 3 of 8'hFF with 8'h00 buffered -> tx_out=IDLE_BIT and tx_en=0 immediately; din_ready=1 after release; no further frame without a new handshake.
REQ-035 din=8'h05 (payload 0,0,0,0,0,1,0,1), next word handshaked on the edge of the trailing stuff bit -> line tail 1,0,1,S1; IDLE for 1 cycle; next sync begins the following cycle.
